// File: rtl/timer_counter_if.sv
// Bridge-side bus for one timer window: decode select, byte-enabled store path,
// and the combinational load data returned by the timer.
interface timer_counter_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, byteen, wdata, input rdata);
  modport slave  (input sel, we, addr, byteen, wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes; raises
// irq when the count expires and the interrupt mask is set.
module timer_counter (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus,
  output logic           irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        wr_en;
  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        unused_addr;

  assign wr_en       = bus.sel & bus.we;
  assign reg_sel     = bus.addr[3:2];
  assign wr_ctrl     = wr_en && (reg_sel == 2'd0);
  assign wr_preset   = wr_en && (reg_sel == 2'd1);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d    = preset_q;
        irq_flag_d = 1'b0;
        state_d    = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Software writes are applied after the FSM so a coincident CTRL store
    // overrides the one-shot enable clear.
    if (wr_ctrl) begin
      if (bus.byteen[0]) ctrl_d = bus.wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.byteen[i]) preset_d[8*i +: 8] = bus.wdata[8*i +: 8];
      end
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (reg_sel)
      2'd0:    bus.rdata = {28'd0, ctrl_q};
      2'd1:    bus.rdata = preset_q;
      2'd2:    bus.rdata = count_q;
      default: bus.rdata = '0;
    endcase
  end

  assign irq = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// preset/mode runs compared against an arithmetic timeline model.
module tb_timer_counter;

  localparam logic [31:0] A_CTRL   = 32'h7f00;
  localparam logic [31:0] A_PRESET = 32'h7f04;
  localparam logic [31:0] A_COUNT  = 32'h7f08;
  localparam logic [31:0] A_RSVD   = 32'h7f0c;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.byteen = '0; bus.wdata = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.byteen = be; bus.wdata = d;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    v = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expected COUNT t edges after the enabling CTRL write (t=0 is that edge).
  function automatic logic [31:0] exp_cnt(int t, int n, bit auto_m, logic [31:0] old);
    int m;
    int u;
    m = (n < 1) ? 1 : n;
    if (t < 2) return old;
    u = t - 2;
    if (auto_m) u = u % (m + 2);
    if (u < m) return 32'(n - u);
    return 32'd0;
  endfunction

  function automatic logic exp_irq(int t, int n, bit auto_m, bit im);
    int m;
    int u;
    m = (n < 1) ? 1 : n;
    if (!im || t < 2) return 1'b0;
    u = t - 2;
    if (auto_m) return ((u % (m + 2)) == m);
    return (u >= m);
  endfunction

  // Enables the timer and checks COUNT, irq and CTRL on every cycle.
  task automatic run_timeline(input int n, input logic [1:0] mode, input logic im,
                              input int cycles, input logic [31:0] old, input string tag);
    logic [31:0] v;
    logic [31:0] ec;
    logic [31:0] ectrl;
    logic        ei;
    bit          auto_m;
    int          m;
    auto_m = (mode == 2'b01);
    m = (n < 1) ? 1 : n;
    wr(A_CTRL, 4'b0001, {28'd0, im, mode, 1'b1});
    for (int t = 0; t < cycles; t++) begin
      ec = exp_cnt(t, n, auto_m, old);
      ei = exp_irq(t, n, auto_m, im);
      ectrl = {28'd0, im, mode, (auto_m || t < 3 + m) ? 1'b1 : 1'b0};
      rd(A_COUNT, v);
      total++;
      if (v !== ec) begin
        bad++;
        $display("FAIL %s count t=%0d: got %0d expected %0d", tag, t, v, ec);
      end
      total++;
      if (irq !== ei) begin
        bad++;
        $display("FAIL %s irq t=%0d: got %b expected %b", tag, t, irq, ei);
      end
      rd(A_CTRL, v);
      total++;
      if (v !== ectrl) begin
        bad++;
        $display("FAIL %s ctrl t=%0d: got %h expected %h", tag, t, v, ectrl);
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    do_reset();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_read %h: got %h expected 0", addrs[i], v);
      end
    end
  endtask

  task automatic test_partial_preset();
    logic [31:0] v;
    logic [31:0] model;
    logic [31:0] d;
    logic [3:0]  be;
    do_reset();
    wr(A_PRESET, 4'b1111, 32'hAABBCCDD);
    wr(A_PRESET, 4'b0011, 32'h11223344);
    rd(A_PRESET, v);
    total++;
    if (v !== 32'hAABB3344) begin
      bad++;
      $display("FAIL partial_preset: got %h expected aabb3344", v);
    end
    model = 32'hAABB3344;
    for (int k = 0; k < 6; k++) begin
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      wr(A_PRESET, be, d);
      for (int b = 0; b < 4; b++)
        if (be[b]) model[8*b +: 8] = d[8*b +: 8];
      rd(A_PRESET, v);
      total++;
      if (v !== model) begin
        bad++;
        $display("FAIL rand_preset be=%b: got %h expected %h", be, v, model);
      end
    end
    wr(A_COUNT, 4'b1111, 32'h12345678);
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL count_write_ignored: got %h expected 0", v);
    end
    wr(A_RSVD, 4'b1111, 32'hFFFFFFFF);
    rd(A_RSVD, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reserved_read: got %h expected 0", v);
    end
    wr(A_CTRL, 4'b1111, 32'hFFFFFFF0);
    rd(A_CTRL, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL ctrl_upper_bits: got %h expected 0", v);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(A_PRESET, 4'b1111, 32'd5);
    run_timeline(5, 2'b00, 1'b1, 14, 32'd0, "oneshot");
    wr(A_CTRL, 4'b0001, 32'h8);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
    end
    rd(A_CTRL, v);
    total++;
    if (v !== 32'h8) begin
      bad++;
      $display("FAIL oneshot_ctrl_after: got %h expected 8", v);
    end
  endtask

  task automatic test_autoreload();
    do_reset();
    wr(A_PRESET, 4'b1111, 32'd3);
    run_timeline(3, 2'b01, 1'b1, 20, 32'd0, "autoreload");
  endtask

  task automatic test_random();
    int         n;
    logic [1:0] mode;
    logic       im;
    for (int k = 0; k < 10; k++) begin
      n    = $urandom_range(0, 9);
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      do_reset();
      wr(A_PRESET, 4'b1111, 32'(n));
      run_timeline(n, mode, im, 3 * (n + 3) + 4, 32'd0, "random");
    end
  endtask

  task automatic test_pause();
    logic [31:0] v;
    do_reset();
    wr(A_PRESET, 4'b1111, 32'd10);
    wr(A_CTRL, 4'b0001, 32'h9);
    for (int i = 0; i < 5; i++) step();
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd7) begin
      bad++;
      $display("FAIL pause_precount: got %0d expected 7", v);
    end
    wr(A_CTRL, 4'b0001, 32'h8);
    for (int i = 0; i < 4; i++) begin
      rd(A_COUNT, v);
      total++;
      if (v !== 32'd6) begin
        bad++;
        $display("FAIL pause_frozen c=%0d: got %0d expected 6", i, v);
      end
      step();
    end
    wr(A_PRESET, 4'b1111, 32'd2);
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd6) begin
      bad++;
      $display("FAIL pause_preset_change: got %0d expected 6", v);
    end
    run_timeline(2, 2'b00, 1'b1, 8, 32'd6, "resume");
  endtask

  task automatic test_boundary();
    logic [31:0] v;
    do_reset();
    wr(A_PRESET, 4'b1111, 32'd2);
    wr(A_CTRL, 4'b0001, 32'h9);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL boundary_int_irq: got %b expected 1", irq);
    end
    wr(A_CTRL, 4'b0001, 32'h9);
    rd(A_CTRL, v);
    total++;
    if (v !== 32'h9) begin
      bad++;
      $display("FAIL sw_write_wins ctrl: got %h expected 9", v);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL sw_write_wins irq: got %b expected 0", irq);
    end
    reset = 1'b1;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = A_PRESET; bus.byteen = 4'hF; bus.wdata = 32'h1234;
    step();
    bus_idle();
    reset = 1'b0;
    rd(A_PRESET, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reset_beats_write: got %h expected 0", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    wr(A_PRESET, 4'b1111, 32'd20);
    wr(A_CTRL, 4'b0001, 32'hB);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(A_COUNT, v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_mid_count c=%0d: got %0d expected 0", i, v);
      end
      rd(A_CTRL, v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_mid_ctrl c=%0d: got %h expected 0", i, v);
      end
      step();
    end
    wr(A_PRESET, 4'b1111, 32'd1);
    wr(A_CTRL, 4'b0001, 32'h9);
    for (int i = 0; i < 6; i++) step();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL reset_flag_pre: got %b expected 1", irq);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_flag_clear: got %b expected 0", irq);
    end
    rd(A_PRESET, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reset_flag_preset: got %h expected 0", v);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    test_reset();
    test_partial_preset();
    test_oneshot();
    test_autoreload();
    test_random();
    test_pause();
    test_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
